// File: rtl/cursor_action_scheduler.sv
// rtl/cursor_action_scheduler.sv - console cursor owner; round-robin arbitration of parser commands and char advances
// Optional feature macro: CURSOR_AUTOWRAP_EN (char advance wraps lines and scrolls at the bottom-right cell)
module cursor_action_scheduler #(
  parameter int CONSOLE_LINES   = 24,
  parameter int CONSOLE_COLUMNS = 80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_type,
  input  logic [7:0] pn1,
  input  logic [7:0] pn2,
  output logic       cmd_ready,
  input  logic       chr_valid,
  output logic       chr_ready,
  output logic [7:0] cursor_x,
  output logic [7:0] cursor_y,
  output logic       scroll_req,
  input  logic       scroll_ack,
  output logic       busy
);

  typedef enum logic {IDLE = 1'b0, SCROLL_WAIT = 1'b1} state_e;

  localparam logic [8:0] NUM_X  = 9'(CONSOLE_COLUMNS);
  localparam logic [8:0] NUM_Y  = 9'(CONSOLE_LINES);
  localparam logic [8:0] LAST_X = 9'(CONSOLE_COLUMNS - 1);
  localparam logic [8:0] LAST_Y = 9'(CONSOLE_LINES - 1);

  state_e     state_q, state_d;
  logic       rr_q, rr_d;
  logic [7:0] x_q, x_d, y_q, y_d;
  logic [8:0] p1, p2, x9, y9, sum_x, sum_y, cup_x, cup_y;
  logic       at_last_x;

  // Zero parameters mean 1; 9-bit intermediates keep sums and differences from wrapping.
  assign p1     = (pn1 == 8'd0) ? 9'd1 : {1'b0, pn1};
  assign p2     = (pn2 == 8'd0) ? 9'd1 : {1'b0, pn2};
  assign x9     = {1'b0, x_q};
  assign y9     = {1'b0, y_q};
  assign sum_x  = x9 + p1;
  assign sum_y  = y9 + p1;
  assign cup_y  = (p1 > NUM_Y) ? NUM_Y : p1;
  assign cup_x  = (p2 > NUM_X) ? NUM_X : p2;
  assign at_last_x = (x9 == LAST_X);

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    x_d       = x_q;
    y_d       = y_q;
    cmd_ready = 1'b0;
    chr_ready = 1'b0;
    case (state_q)
      IDLE: begin
        // rr_q==0 favours the parser on contention; the pointer only moves when both compete.
        if (cmd_valid && chr_valid) begin
          cmd_ready = ~rr_q;
          chr_ready = rr_q;
          rr_d      = ~rr_q;
        end else begin
          cmd_ready = cmd_valid;
          chr_ready = chr_valid;
        end
        if (cmd_ready) begin
          case (cmd_type)
            3'd0: begin
              y_d = 8'(cup_y - 9'd1);
              x_d = 8'(cup_x - 9'd1);
            end
            3'd1: y_d = (p1 >= y9) ? 8'd0 : 8'(y9 - p1);
            3'd2: y_d = (sum_y > LAST_Y) ? LAST_Y[7:0] : sum_y[7:0];
            3'd3: x_d = (sum_x > LAST_X) ? LAST_X[7:0] : sum_x[7:0];
            3'd4: x_d = (p1 >= x9) ? 8'd0 : 8'(x9 - p1);
            default: ;
          endcase
        end else if (chr_ready) begin
          if (!at_last_x) begin
            x_d = x_q + 8'd1;
          end
`ifdef CURSOR_AUTOWRAP_EN
          else if (y9 != LAST_Y) begin
            x_d = 8'd0;
            y_d = y_q + 8'd1;
          end else begin
            x_d     = 8'd0;
            state_d = SCROLL_WAIT;
          end
`endif
        end
      end
      SCROLL_WAIT: begin
        if (scroll_ack) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      x_q     <= 8'd0;
      y_q     <= 8'd0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign cursor_x = x_q;
  assign cursor_y = y_q;
  assign busy     = (state_q != IDLE);
`ifdef CURSOR_AUTOWRAP_EN
  assign scroll_req = (state_q == SCROLL_WAIT);
`else
  assign scroll_req = 1'b0;
`endif

endmodule

// File: tb/tb_cursor_action_scheduler.sv
// tb/tb_cursor_action_scheduler.sv - randomized self-checking bench for cursor_action_scheduler
// Follows CURSOR_AUTOWRAP_EN the same way the design does.
module tb_cursor_action_scheduler;

  localparam int L = 24;
  localparam int C = 80;
`ifdef CURSOR_AUTOWRAP_EN
  localparam bit AUTOWRAP = 1'b1;
`else
  localparam bit AUTOWRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_type = 3'd0;
  logic [7:0] pn1 = 8'd0;
  logic [7:0] pn2 = 8'd0;
  logic       cmd_ready;
  logic       chr_valid = 1'b0;
  logic       chr_ready;
  logic [7:0] cursor_x;
  logic [7:0] cursor_y;
  logic       scroll_req;
  logic       scroll_ack = 1'b0;
  logic       busy;

  int checks = 0;
  int passes = 0;

  // Reference model: cursor as plain integers, arbitration as a "who goes first" flag.
  int m_x, m_y;
  bit m_chr_first;
  bit m_scrolling;

  logic [19:0] act, exp;
  logic        act_cr, act_hr;

  cursor_action_scheduler #(.CONSOLE_LINES(L), .CONSOLE_COLUMNS(C)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type), .pn1(pn1), .pn2(pn2), .cmd_ready(cmd_ready),
    .chr_valid(chr_valid), .chr_ready(chr_ready),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
    .scroll_req(scroll_req), .scroll_ack(scroll_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
  function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_chr_first = 1'b0; m_scrolling = 1'b0;
  endtask

  task automatic model_cmd(input int t, input int a, input int b);
    if (a == 0) a = 1;
    if (b == 0) b = 1;
    case (t)
      0: begin m_y = imin(a, L) - 1; m_x = imin(b, C) - 1; end
      1: m_y = imax(m_y - a, 0);
      2: m_y = imin(m_y + a, L - 1);
      3: m_x = imin(m_x + a, C - 1);
      4: m_x = imax(m_x - a, 0);
      default: ;
    endcase
  endtask

  task automatic model_chr();
    if (m_x < C - 1) m_x = m_x + 1;
    else if (AUTOWRAP) begin
      m_x = 0;
      if (m_y < L - 1) m_y = m_y + 1;
      else m_scrolling = 1'b1;
    end
  endtask

  // One clock of stimulus; leaves observed and predicted {readies, x, y, scroll_req, busy} in act/exp.
  task automatic drive(input bit cv, input bit [2:0] ct, input bit [7:0] a, input bit [7:0] b,
                       input bit hv, input bit ack);
    bit ecr, ehr;
    @(negedge clk);
    cmd_valid = cv; cmd_type = ct; pn1 = a; pn2 = b; chr_valid = hv; scroll_ack = ack;
    #1;
    act_cr = cmd_ready;
    act_hr = chr_ready;
    ecr = 1'b0; ehr = 1'b0;
    if (!m_scrolling) begin
      if (cv && hv) begin
        ecr = !m_chr_first; ehr = m_chr_first; m_chr_first = !m_chr_first;
      end else begin
        ecr = cv; ehr = hv;
      end
      if (ecr) model_cmd(int'(ct), int'(a), int'(b));
      else if (ehr) model_chr();
    end else if (ack) begin
      m_scrolling = 1'b0;
    end
    @(posedge clk);
    #1;
    act = {act_cr, act_hr, cursor_x, cursor_y, scroll_req, busy};
    exp = {ecr, ehr, 8'(m_x), 8'(m_y), m_scrolling, m_scrolling};
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    cmd_valid = 1'b0; chr_valid = 1'b0; scroll_ack = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    cmd_valid = 1'b0; chr_valid = 1'b0; scroll_ack = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    #12;
    checks++;
    if ({cursor_x, cursor_y, scroll_req, busy, cmd_ready, chr_ready} !== 20'd0)
      $display("FAIL reset_state: got x=%0d y=%0d sr=%b busy=%b rdy=%b%b want all 0",
               cursor_x, cursor_y, scroll_req, busy, cmd_ready, chr_ready);
    else passes++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_commands();
    drive(1, 3'd0, 8'd5, 8'd10, 0, 0);
    checks++;
    if (act !== exp || act_cr !== 1'b1 || cursor_x !== 8'd9 || cursor_y !== 8'd4)
      $display("FAIL cup_5_10: got %h want %h (x=9 y=4)", act, exp);
    else passes++;
    drive(1, 3'd4, 8'd200, 8'd0, 0, 0);
    checks++;
    if (act !== exp || cursor_x !== 8'd0) $display("FAIL cub_200: got %h want %h", act, exp);
    else passes++;
    drive(1, 3'd3, 8'd0, 8'd0, 0, 0);
    checks++;
    if (act !== exp || cursor_x !== 8'd1) $display("FAIL cuf_0: got %h want %h", act, exp);
    else passes++;
    drive(1, 3'd0, 8'd99, 8'd200, 0, 0);
    checks++;
    if (act !== exp || cursor_x !== 8'd79 || cursor_y !== 8'd23)
      $display("FAIL cup_clamp: got %h want %h", act, exp);
    else passes++;
    drive(1, 3'd2, 8'd255, 8'd0, 0, 0);
    checks++;
    if (act !== exp) $display("FAIL cud_255: got %h want %h", act, exp); else passes++;
    drive(1, 3'd1, 8'd255, 8'd0, 0, 0);
    checks++;
    if (act !== exp || cursor_y !== 8'd0) $display("FAIL cuu_255: got %h want %h", act, exp);
    else passes++;
    drive(1, 3'd6, 8'd3, 8'd3, 0, 0);
    checks++;
    if (act !== exp || act_cr !== 1'b1) $display("FAIL reserved: got %h want %h", act, exp);
    else passes++;
    idle_inputs();
  endtask

  task automatic test_line_wrap();
    drive(1, 3'd0, 8'd6, 8'd80, 0, 0);
    drive(0, 3'd0, 8'd0, 8'd0, 1, 0);
    checks++;
    if (act !== exp || scroll_req !== 1'b0 || busy !== 1'b0 ||
        cursor_x !== (AUTOWRAP ? 8'd0 : 8'd79) || cursor_y !== (AUTOWRAP ? 8'd6 : 8'd5))
      $display("FAIL line_wrap: got %h want %h", act, exp);
    else passes++;
    idle_inputs();
  endtask

  task automatic test_scroll();
    drive(1, 3'd0, 8'd24, 8'd80, 0, 0);
    drive(0, 3'd0, 8'd0, 8'd0, 1, 0);
    checks++;
    if (act !== exp || scroll_req !== AUTOWRAP || busy !== AUTOWRAP ||
        cursor_x !== (AUTOWRAP ? 8'd0 : 8'd79) || cursor_y !== 8'd23)
      $display("FAIL scroll_enter: got %h want %h", act, exp);
    else passes++;
    if (AUTOWRAP) begin
      for (int i = 0; i < 5; i++) begin
        drive(1, 3'd3, 8'd1, 8'd0, 0, 0);
        checks++;
        if (act !== exp || act_cr !== 1'b0)
          $display("FAIL scroll_hold[%0d]: got %h want %h", i, act, exp);
        else passes++;
      end
      drive(1, 3'd3, 8'd1, 8'd0, 0, 1);
      checks++;
      if (act !== exp || scroll_req !== 1'b0) $display("FAIL scroll_ack: got %h want %h", act, exp);
      else passes++;
      drive(1, 3'd3, 8'd1, 8'd0, 0, 0);
      checks++;
      if (act !== exp || act_cr !== 1'b1) $display("FAIL scroll_regrant: got %h want %h", act, exp);
      else passes++;
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    bit [3:0] grants;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 3'd3, 8'd1, 8'd0, 1, 0);
      grants[3-i] = act_cr;
      checks++;
      if (act !== exp) $display("FAIL rr_cycle[%0d]: got %h want %h", i, act, exp);
      else passes++;
    end
    checks++;
    if (grants !== 4'b1010) $display("FAIL rr_order: got cmd grants %b want 1010", grants);
    else passes++;
    idle_inputs();
  endtask

  task automatic test_async_reset();
    drive(1, 3'd0, 8'd24, 8'd80, 0, 0);
    drive(0, 3'd0, 8'd0, 8'd0, 1, 0);
    @(negedge clk);
    chr_valid = 1'b0;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({cursor_x, cursor_y, scroll_req, busy} !== 18'd0)
      $display("FAIL async_reset: got x=%0d y=%0d sr=%b busy=%b want 0 0 0 0",
               cursor_x, cursor_y, scroll_req, busy);
    else passes++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_random();
    bit [7:0] a, b;
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 30));
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(70, 90));
      drive(($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), a, b,
            ($urandom_range(0, 1) != 0), ($urandom_range(0, 3) == 0));
      checks++;
      if (act !== exp) $display("FAIL random[%0d]: got %h want %h", i, act, exp);
      else passes++;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_commands();
    test_line_wrap();
    test_scroll();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
